univ_reg_ctrl: RTL
==================

# univ_reg_ctrl

Command sequencer for the 4-bit universal shift register. It accepts one operation at a time over a valid/ready handshake and drives the register's `select`, `ssl`, `ssr` and `i` inputs for the required number of cycles. It watches the register's `a` output to produce rotate and arithmetic-shift fill bits. It also gives the reset-less register a defined post-reset value.

## Interface
- `CNT_W`, default 3: width of `cmd_count`. Maximum repeat is 2^CNT_W−1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command. High only in IDLE.
- `cmd_op` input 3: 000 NOP, 001 LOAD, 010 CLEAR, 011 SHL, 100 SHR, 101 ROTL, 110 ROTR, 111 ASR.
- `cmd_count` input CNT_W: shift/rotate repeat count. Ignored by LOAD, CLEAR and NOP.
- `cmd_data` input 4: parallel value for LOAD.
- `cmd_fill` input 1: fill bit for SHL/SHR.
- `reg_q` input 4: register output `a`.
- `reg_sel` output 2: register `select`.
- `reg_ssl` output 1: register `ssl`.
- `reg_ssr` output 1: register `ssr`.
- `reg_i` output 4: register `i`.
- `busy` output 1: high in INIT, RUN and DONE.
- `done` output 1: one-cycle completion pulse.

## Operation
- Register select encoding:
  - 00: hold.
  - 01: shift toward bit 0 ("right"); `ssr` enters bit 3.
  - 10: shift toward bit 3 ("left"); `ssl` enters bit 0.
  - 11: parallel load from `i`.
- States: INIT, IDLE, RUN, DONE.
- INIT:
  - Drives sel=11, i=0000.
  - Lasts one clock after `rst` deasserts, then goes to IDLE.
  - `rst` high forces INIT, so the register is loaded with 0 on every edge during reset.
- IDLE:
  - Drives sel=00 (hold) with `cmd_ready`=1.
  - Accept occurs on an edge where valid && ready. On accept, latch op, count, data and fill.
  - NOP, or a repeat op with count 0, goes straight to DONE.
  - Any other op goes to RUN.
- RUN:
  - LOAD: one cycle, sel=11, i=data.
  - CLEAR: one cycle, sel=11, i=0.
  - SHL: sel=10, ssl=fill.
  - SHR: sel=01, ssr=fill.
  - ROTL: sel=10, ssl=reg_q[3].
  - ROTR: sel=01, ssr=reg_q[0].
  - ASR: sel=01, ssr=reg_q[3].
  - Repeat ops stay in RUN for exactly `count` cycles. An internal down-counter is loaded with count at accept and decremented each RUN cycle. The block leaves RUN in the cycle where the counter equals 1.
  - Fill bits are combinational from the current `reg_q`, so each step uses the value updated by the previous step.
  - Counts above 4 are legal. Rotates wrap, and shifts saturate to fill.
- DONE: `done`=1 for one cycle, sel=00, then IDLE.
- Unused outputs:
  - `reg_ssl`/`reg_ssr` are 0 unless named above.
  - `reg_i` is 0 except during LOAD.
- `cmd_*` inputs are ignored whenever `cmd_ready`=0.

## Timing
- All outputs are valid from reset assertion with no clock: state=INIT, `cmd_ready`=0, `busy`=1, `done`=0, sel=11, i=0000, ssl=ssr=0.
- First accept is possible on the 2nd rising edge after `rst` deasserts.
- Accept at edge E0 of an op with N effective steps (LOAD/CLEAR = 1):
  - The register updates on edges E1..EN.
  - `done` is high in the cycle after EN, and `reg_q` then holds the final value.
  - `cmd_ready` is high again one cycle after `done`.
  - Latency from accept to `done` is N+1 cycles.
- Zero-step command: `done` in the cycle after E0.
- Back-to-back commands: minimum issue interval is N+2 cycles.
- `rst` mid-operation: immediate abort to INIT. No `done` is produced, and the register is cleared.

## Structure
- Shared package `univ_reg_pkg` holds:
  - the op enum (3-bit);
  - select constants SEL_HOLD=00, SEL_RIGHT=01, SEL_LEFT=10, SEL_LOAD=11;
  - the state enum.
- One state register plus the down-counter, with combinational output decode.
- Natural sub-module: `univ_reg_sys`, a top that instantiates `univ_reg_ctrl` and the universal register and wires `reg_q` back. Benches use this top.

## Test plan
- Reset release: `reg_q`=0000 after INIT; `cmd_ready` rises 1 cycle after `rst` falls; `done`=0 throughout.
- LOAD 1011: `reg_q`=1011 on the edge after accept; `done` pulses next cycle; then `cmd_ready`=1.
- From 1011, ROTL count 3: steps 0111, 1110, 1101. `done` 4 cycles after accept.
- From 1011:
  - SHR count 2 fill=1: steps 1101, 1110.
  - Then ASR count 2 on 1000 (reload first): steps 1100, 1110.
- Count 0 ROTR and NOP: `reg_q` unchanged; `done` 1 cycle after accept. `cmd_valid` held high during `busy` is not accepted until `cmd_ready`.
- ROTL count 5 from 0001, `rst` pulsed after 2 steps: register returns to 0000, no `done`. A new LOAD 0110 then completes normally.

Source files
------------

// File: rtl/univ_reg_pkg.sv
// Shared definitions for the universal shift register sequencer.
package univ_reg_pkg;

    // Command opcodes as presented on cmd_op.
    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_CLEAR = 3'b010,
        OP_SHL   = 3'b011,
        OP_SHR   = 3'b100,
        OP_ROTL  = 3'b101,
        OP_ROTR  = 3'b110,
        OP_ASR   = 3'b111
    } op_e;

    // Register select encoding.
    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_IDLE = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Shift/rotate ops honour cmd_count; the others are single-shot.
    function automatic logic is_repeat(input op_e op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROTL) ||
               (op == OP_ROTR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/univ_reg_ctrl.sv
// Command sequencer for the 4-bit universal shift register. Accepts one
// command at a time, steps the register for the required number of cycles
// and derives rotate / arithmetic-shift fill bits from the register output.
module univ_reg_ctrl
    import univ_reg_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [3:0]       cmd_data,
    input  logic             cmd_fill,
    input  logic [3:0]       reg_q,
    output logic [1:0]       reg_sel,
    output logic             reg_ssl,
    output logic             reg_ssr,
    output logic [3:0]       reg_i,
    output logic             busy,
    output logic             done
);

    state_e           state;
    op_e              op_q;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       data_q;
    logic             fill_q;
    op_e              op_in;

    assign op_in = op_e'(cmd_op);

    // State register, command latch and step down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_INIT;
            op_q   <= OP_NOP;
            cnt    <= '0;
            data_q <= '0;
            fill_q <= 1'b0;
        end else begin
            case (state)
                ST_INIT: state <= ST_IDLE;
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= op_in;
                        cnt    <= cmd_count;
                        data_q <= cmd_data;
                        fill_q <= cmd_fill;
                        // Nothing to step: report completion right away.
                        if (op_in == OP_NOP || (is_repeat(op_in) && cmd_count == '0))
                            state <= ST_DONE;
                        else
                            state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (!is_repeat(op_q) || cnt == CNT_W'(1))
                        state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output decode; fill bits track the live register value each step.
    always_comb begin
        reg_sel = SEL_HOLD;
        reg_ssl = 1'b0;
        reg_ssr = 1'b0;
        reg_i   = 4'b0000;
        case (state)
            ST_INIT: reg_sel = SEL_LOAD;
            ST_RUN: begin
                case (op_q)
                    OP_LOAD: begin
                        reg_sel = SEL_LOAD;
                        reg_i   = data_q;
                    end
                    OP_CLEAR: reg_sel = SEL_LOAD;
                    OP_SHL: begin
                        reg_sel = SEL_LEFT;
                        reg_ssl = fill_q;
                    end
                    OP_SHR: begin
                        reg_sel = SEL_RIGHT;
                        reg_ssr = fill_q;
                    end
                    OP_ROTL: begin
                        reg_sel = SEL_LEFT;
                        reg_ssl = reg_q[3];
                    end
                    OP_ROTR: begin
                        reg_sel = SEL_RIGHT;
                        reg_ssr = reg_q[0];
                    end
                    OP_ASR: begin
                        reg_sel = SEL_RIGHT;
                        reg_ssr = reg_q[3];
                    end
                    default: reg_sel = SEL_HOLD;
                endcase
            end
            default: reg_sel = SEL_HOLD;
        endcase
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule
